spi_host: RTL and testbench

SPI controller (initiator) that serialises 8-bit command bytes onto a 3-wire SPI link (spi_clk, mosi, cs) for the FPGA-side `spi_client`. It sits in the controlling design, or in the bench as the stimulus driver. The upper nibble of each byte selects the waveform generator's wave/frequency on the client side. Mode 0 (CPOL=0, CPHA=0), MSB first, cs active-low, one byte per cs-low frame.

---
 rtl/spi_host.sv | 120 ++++++++++++
 tb/tb_spi_host.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_host.sv
// Mode-0 SPI initiator: sends one 8-bit command per cs-low frame, MSB first.
// One divider counter paces every phase; a 4-bit edge counter walks the 16 spi_clk half-periods.
module spi_host #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,        // synchronous, active-low
  input  logic [7:0] cmd_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  output logic       spi_clk_o,
  output logic       mosi_o,
  output logic       cs_o,
  output logic       done_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam logic [7:0] TC = 8'(CLK_DIV - 1);

  state_t     state_q;
  logic [7:0] cnt_q;
  logic [3:0] edge_q;
  logic [7:0] sr_q;
  logic       spi_clk_q;
  logic       mosi_q;
  logic       cs_q;
  logic       done_q;
  logic       tc;

  assign tc = (cnt_q == TC);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      edge_q    <= '0;
      sr_q      <= '0;
      spi_clk_q <= 1'b0;
      mosi_q    <= 1'b0;
      cs_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (cmd_valid_i) begin
            state_q <= SETUP;
            sr_q    <= cmd_i;
            mosi_q  <= cmd_i[7];
            cs_q    <= 1'b0;
          end
        end
        SETUP: begin
          if (tc) begin
            cnt_q     <= '0;
            edge_q    <= '0;
            spi_clk_q <= 1'b1;
            state_q   <= SHIFT;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        SHIFT: begin
          if (tc) begin
            cnt_q <= '0;
            // Half-period 15 is the low phase after the last fall; leave without toggling.
            if (edge_q == 4'd15) begin
              edge_q  <= '0;
              state_q <= HOLD;
            end else begin
              edge_q    <= edge_q + 4'd1;
              spi_clk_q <= ~spi_clk_q;
              if (spi_clk_q && edge_q != 4'd14) begin
                sr_q   <= {sr_q[6:0], 1'b0};
                mosi_q <= sr_q[6];
              end
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        HOLD: begin
          if (tc) begin
            cnt_q   <= '0;
            cs_q    <= 1'b1;
            done_q  <= 1'b1;
            mosi_q  <= 1'b0;
            state_q <= GAP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        GAP: begin
          if (tc) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign spi_clk_o   = spi_clk_q;
  assign mosi_o      = mosi_q;
  assign cs_o        = cs_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_spi_host.sv
// Directed bench for spi_host at CLK_DIV=4 and CLK_DIV=1; a line monitor decodes each
// cs-low frame into a record that is scored against bytes queued when they were sent.
module tb_spi_host;

  typedef struct packed {
    logic [7:0]  b;
    logic [7:0]  rises;
    logic [15:0] cs_len;
    logic [15:0] gap;
    logic        done;
    logic        stable;
  } frame_t;

  logic       clk;
  logic       rst;
  logic [7:0] cmd4, cmd1;
  logic       val4, val1;
  logic       rdy4, sc4, mo4, cs4, dn4;
  logic       rdy1, sc1, mo1, cs1, dn1;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] exp4[$];
  logic [7:0] exp1[$];
  frame_t     obs4[$];
  frame_t     obs1[$];
  int         rd4 = 0;
  int         rd1 = 0;

  spi_host #(.CLK_DIV(4)) u_d4 (
    .clk_i(clk), .rst_i(rst), .cmd_i(cmd4), .cmd_valid_i(val4),
    .cmd_ready_o(rdy4), .spi_clk_o(sc4), .mosi_o(mo4), .cs_o(cs4), .done_o(dn4)
  );

  spi_host #(.CLK_DIV(1)) u_d1 (
    .clk_i(clk), .rst_i(rst), .cmd_i(cmd1), .cmd_valid_i(val1),
    .cmd_ready_o(rdy1), .spi_clk_o(sc1), .mosi_o(mo1), .cs_o(cs1), .done_o(dn1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] cs_v, sc_v, mo_v, dn_v;
  assign cs_v = {cs1, cs4};
  assign sc_v = {sc1, sc4};
  assign mo_v = {mo1, mo4};
  assign dn_v = {dn1, dn4};

  // Line monitor: index 0 watches the D=4 instance, index 1 the D=1 instance.
  logic [7:0] m_sh[2];
  int         m_rises[2];
  int         m_len[2];
  int         m_gap[2];
  int         m_gap_pre[2];
  logic       m_stable[2];
  logic       m_sc_prev[2] = '{1'b0, 1'b0};
  logic       m_mo_prev[2] = '{1'b0, 1'b0};
  logic       m_cs_prev[2] = '{1'b1, 1'b1};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      frame_t f;
      if (cs_v[i] === 1'b0) begin
        if (m_cs_prev[i]) begin
          m_gap_pre[i] = m_gap[i];
          m_len[i]     = 0;
          m_rises[i]   = 0;
          m_sh[i]      = 8'h00;
          m_stable[i]  = 1'b1;
        end
        m_len[i] = m_len[i] + 1;
        if (sc_v[i] && !m_sc_prev[i]) begin
          m_rises[i] = m_rises[i] + 1;
          m_sh[i]    = {m_sh[i][6:0], mo_v[i]};
          if (mo_v[i] !== m_mo_prev[i]) m_stable[i] = 1'b0;
        end
      end else begin
        if (!m_cs_prev[i]) begin
          f.b      = m_sh[i];
          f.rises  = 8'(m_rises[i]);
          f.cs_len = 16'(m_len[i]);
          f.gap    = 16'(m_gap_pre[i]);
          f.done   = dn_v[i];
          f.stable = m_stable[i];
          if (i == 0) obs4.push_back(f);
          else        obs1.push_back(f);
          m_gap[i] = 0;
        end
        m_gap[i] = m_gap[i] + 1;
      end
      m_sc_prev[i] = sc_v[i];
      m_mo_prev[i] = mo_v[i];
      m_cs_prev[i] = (cs_v[i] !== 1'b0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int sel, input logic [7:0] b, input bit push);
    int n = 0;
    @(negedge clk);
    if (sel == 0) begin cmd4 = b; val4 = 1'b1; end
    else          begin cmd1 = b; val1 = 1'b1; end
    while (((sel == 0) ? rdy4 : rdy1) !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", (sel == 0) ? rdy4 : rdy1, 1);
    if (push) begin
      if (sel == 0) exp4.push_back(b);
      else          exp1.push_back(b);
    end
    @(posedge clk);
    #1;
    if (sel == 0) val4 = 1'b0;
    else          val1 = 1'b0;
  endtask

  task automatic wait_rec(input int sel, output frame_t r);
    int n = 0;
    while (((sel == 0) ? obs4.size() <= rd4 : obs1.size() <= rd1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    n_assert++;
    assert ((sel == 0) ? obs4.size() > rd4 : obs1.size() > rd1) else begin
      n_fail++;
      $error("FAIL rec_timeout: observed no frame expected a frame on instance %0d", sel);
    end
    r = '0;
    if (sel == 0 && obs4.size() > rd4) begin r = obs4[rd4]; rd4++; end
    if (sel == 1 && obs1.size() > rd1) begin r = obs1[rd1]; rd1++; end
  endtask

  task automatic check_frame(input int sel, input frame_t r);
    logic [7:0] e;
    e = 8'h00;
    if (sel == 0 && exp4.size() > 0) e = exp4.pop_front();
    if (sel == 1 && exp1.size() > 0) e = exp1.pop_front();
    check("byte",   r.b, e);
    check("rises",  r.rises, 8);
    check("cs_len", r.cs_len, (sel == 0) ? 72 : 18);
    check("done",   r.done, 1);
    check("stable", r.stable, 1);
  endtask

  initial begin
    frame_t r;
    int     n;
    logic   prev;
    rst  = 1'b0;
    val4 = 1'b1; cmd4 = 8'hAA;
    val1 = 1'b0; cmd1 = 8'h00;

    // Reset held with cmd_valid high: outputs stay at idle values.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_idle", {cs4, sc4, mo4, dn4, rdy4}, 5'b10001);
    end
    val4 = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    check("reset_no_frame", cs4, 1);

    // Single frame, D=4, with done/cmd_ready timing around cs rise.
    send(0, 8'hA5, 1);
    n = 0;
    while (cs4 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cs_rise_done", {cs4, dn4, rdy4}, 3'b110);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) check("done_one_cycle", dn4, 0);
      check("ready_return", rdy4, (i == 4) ? 1 : 0);
    end
    wait_rec(0, r);
    check_frame(0, r);

    // Back-to-back frames with cmd changed while frame 1 is in flight.
    @(negedge clk);
    cmd4 = 8'h30; val4 = 1'b1;
    n = 0;
    while (rdy4 !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    exp4.push_back(8'h30);
    @(posedge clk);
    #1;
    cmd4 = 8'hF0;
    exp4.push_back(8'hF0);
    repeat (10) @(negedge clk);
    n = 0;
    while (rdy4 !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    check("b2b_ready", rdy4, 1);
    @(posedge clk);
    #1;
    val4 = 1'b0;
    wait_rec(0, r);
    check_frame(0, r);
    wait_rec(0, r);
    check_frame(0, r);
    check("b2b_gap", r.gap, 5);

    // Minimum divider.
    send(1, 8'h81, 1);
    wait_rec(1, r);
    check_frame(1, r);

    // Reset after the third rise of a 0xFF frame.
    send(0, 8'hFF, 0);
    n = 0;
    prev = sc4;
    while (n < 3) begin
      @(negedge clk);
      if (sc4 && !prev) n++;
      prev = sc4;
    end
    rst = 1'b0;
    @(negedge clk);
    check("abort_outputs", {cs4, sc4, mo4, dn4, rdy4}, 5'b10001);
    rst = 1'b1;
    wait_rec(0, r);
    check("abort_done", r.done, 0);
    check("abort_rises", r.rises, 3);
    send(0, 8'h12, 1);
    wait_rec(0, r);
    check_frame(0, r);

    // Decoded command nibble, as a client would see it.
    send(0, 8'h50, 1);
    wait_rec(0, r);
    check_frame(0, r);
    check("nibble", r.b[7:4], 4'h5);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
